// File: rtl/pci_avm_arbiter.sv
// rtl/pci_avm_arbiter.sv - two-master arbiter sharing the PCI bridge Avalon memory port
// Grant is held for a full transaction; the bridge takes one outstanding transaction at a time.
module pci_avm_arbiter #(
   parameter int AW         = 22,
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [AW-1:0] m0_address,
   input  logic [31:0]   m0_writedata,
   input  logic [3:0]    m0_byteenable,
   input  logic [3:0]    m0_burstcount,
   input  logic          m0_read,
   input  logic          m0_write,
   output logic          m0_waitrequest,
   output logic          m0_readdatavalid,
   output logic [31:0]   m0_readdata,
   input  logic [AW-1:0] m1_address,
   input  logic [31:0]   m1_writedata,
   input  logic [3:0]    m1_byteenable,
   input  logic [3:0]    m1_burstcount,
   input  logic          m1_read,
   input  logic          m1_write,
   output logic          m1_waitrequest,
   output logic          m1_readdatavalid,
   output logic [31:0]   m1_readdata,
   output logic [AW-1:0] s_address,
   output logic [31:0]   s_writedata,
   output logic [3:0]    s_byteenable,
   output logic [3:0]    s_burstcount,
   output logic          s_read,
   output logic          s_write,
   input  logic          s_waitrequest,
   input  logic          s_readdatavalid,
   input  logic [31:0]   s_readdata,
   output logic [1:0]    grant,
   output logic          busy
);
   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_OWN      = 2'd1;
   localparam logic [1:0] ST_WR_BURST = 2'd2;
   localparam logic [1:0] ST_RD_WAIT  = 2'd3;

   logic [1:0] r_state;
   logic [1:0] r_grant;
   logic       r_last_owner;
   logic [3:0] r_beats;

   logic       w_owner;
   logic       w_req0;
   logic       w_req1;
   logic       w_pick1;
   logic       w_own_rd;
   logic       w_own_wr;
   logic       w_fwd;
   logic       w_rd_acc;
   logic       w_wr_acc;
   logic       w_rdv;
   logic       w_done;
   logic [3:0] w_bc;

   assign w_owner = r_grant[1];
   assign w_req0  = m0_read | m0_write;
   assign w_req1  = m1_read | m1_write;
   // m1 wins a tie only in round-robin mode and only when m0 owned last
   assign w_pick1 = w_req1 & (~w_req0 | (~FIXED_PRIO & ~r_last_owner));

   assign w_own_rd = w_owner ? m1_read  : m0_read;
   assign w_own_wr = w_owner ? m1_write : m0_write;
   assign w_fwd    = (r_state == ST_OWN) | (r_state == ST_WR_BURST);

   assign s_address    = w_owner ? m1_address    : m0_address;
   assign s_writedata  = w_owner ? m1_writedata  : m0_writedata;
   assign s_byteenable = w_owner ? m1_byteenable : m0_byteenable;
   assign s_burstcount = w_owner ? m1_burstcount : m0_burstcount;
   assign s_read       = (r_state == ST_OWN) & w_own_rd;
   assign s_write      = w_fwd & w_own_wr & ~s_read;

   assign m0_waitrequest = ~(w_fwd & ~w_owner) | s_waitrequest;
   assign m1_waitrequest = ~(w_fwd &  w_owner) | s_waitrequest;

   // Read beats outside RD_WAIT have no owner and are dropped
   assign w_rdv            = (r_state == ST_RD_WAIT) & s_readdatavalid;
   assign m0_readdatavalid = w_rdv & ~w_owner;
   assign m1_readdatavalid = w_rdv &  w_owner;
   assign m0_readdata      = s_readdata;
   assign m1_readdata      = s_readdata;

   assign grant = r_grant;
   assign busy  = (r_state != ST_IDLE);

   assign w_bc     = (s_burstcount == 4'd0) ? 4'd1 : s_burstcount;
   assign w_rd_acc = s_read  & ~s_waitrequest;
   assign w_wr_acc = s_write & ~s_waitrequest;
   assign w_done   = ((r_state == ST_OWN)      & ~w_rd_acc & w_wr_acc & (w_bc == 4'd1))
                   | ((r_state == ST_WR_BURST) & w_wr_acc        & (r_beats <= 4'd1))
                   | ((r_state == ST_RD_WAIT)  & s_readdatavalid & (r_beats <= 4'd1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_grant      <= 2'b00;
         r_last_owner <= 1'b1;
         r_beats      <= 4'd0;
      end else if (w_done) begin
         r_last_owner <= w_owner;
         r_grant      <= 2'b00;
         r_state      <= ST_IDLE;
         r_beats      <= 4'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_req0 | w_req1) begin
                  r_grant <= w_pick1 ? 2'b10 : 2'b01;
                  r_state <= ST_OWN;
               end
            end
            ST_OWN: begin
               if (w_rd_acc) begin
                  r_beats <= w_bc;
                  r_state <= ST_RD_WAIT;
               end else if (w_wr_acc) begin
                  r_beats <= w_bc - 4'd1;
                  r_state <= ST_WR_BURST;
               end
            end
            ST_WR_BURST: begin
               if (w_wr_acc) r_beats <= r_beats - 4'd1;
            end
            ST_RD_WAIT: begin
               if (s_readdatavalid) r_beats <= r_beats - 4'd1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_pci_avm_arbiter.sv
// tb/tb_pci_avm_arbiter.sv - scoreboard bench for pci_avm_arbiter
// Per-master expected queues, a bridge model with programmable wait/latency, and a grant log.
module tb_pci_avm_arbiter;
   localparam int AW  = 22;
   localparam int TMO = 200;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [AW-1:0] m_address    [2];
   logic [31:0]   m_writedata  [2];
   logic [3:0]    m_byteenable [2];
   logic [3:0]    m_burstcount [2];
   logic          m_read       [2];
   logic          m_write      [2];
   logic          m_wait       [2];
   logic          m_rdv        [2];
   logic [31:0]   m_rdata      [2];
   logic [AW-1:0] s_address;
   logic [31:0]   s_writedata;
   logic [3:0]    s_byteenable;
   logic [3:0]    s_burstcount;
   logic          s_read, s_write;
   logic          s_waitrequest, s_readdatavalid;
   logic [31:0]   s_readdata;
   logic [1:0]    grant;
   logic          busy;

   pci_avm_arbiter #(.AW(AW), .FIXED_PRIO(1'b0)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .m0_address(m_address[0]), .m0_writedata(m_writedata[0]), .m0_byteenable(m_byteenable[0]),
      .m0_burstcount(m_burstcount[0]), .m0_read(m_read[0]), .m0_write(m_write[0]),
      .m0_waitrequest(m_wait[0]), .m0_readdatavalid(m_rdv[0]), .m0_readdata(m_rdata[0]),
      .m1_address(m_address[1]), .m1_writedata(m_writedata[1]), .m1_byteenable(m_byteenable[1]),
      .m1_burstcount(m_burstcount[1]), .m1_read(m_read[1]), .m1_write(m_write[1]),
      .m1_waitrequest(m_wait[1]), .m1_readdatavalid(m_rdv[1]), .m1_readdata(m_rdata[1]),
      .s_address(s_address), .s_writedata(s_writedata), .s_byteenable(s_byteenable),
      .s_burstcount(s_burstcount), .s_read(s_read), .s_write(s_write),
      .s_waitrequest(s_waitrequest), .s_readdatavalid(s_readdatavalid), .s_readdata(s_readdata),
      .grant(grant), .busy(busy)
   );

   // Fixed-priority instance: both masters read forever against a zero-wait bridge
   logic          fp_w0, fp_w1, fp_v0, fp_v1, fp_s_read, fp_s_write, fp_busy, fp_rdv_in, fp_acc;
   logic [31:0]   fp_d0, fp_d1, fp_s_wdata;
   logic [AW-1:0] fp_s_addr;
   logic [3:0]    fp_s_be, fp_s_bc;
   logic [1:0]    fp_grant, fp_prev;
   int            fp_g0 = 0, fp_g1 = 0;

   pci_avm_arbiter #(.AW(AW), .FIXED_PRIO(1'b1)) u_dut_fp (
      .clk(clk), .rst_n(rst_n),
      .m0_address(22'h000200), .m0_writedata(32'h0), .m0_byteenable(4'hF),
      .m0_burstcount(4'd1), .m0_read(1'b1), .m0_write(1'b0),
      .m0_waitrequest(fp_w0), .m0_readdatavalid(fp_v0), .m0_readdata(fp_d0),
      .m1_address(22'h000300), .m1_writedata(32'h0), .m1_byteenable(4'hF),
      .m1_burstcount(4'd1), .m1_read(1'b1), .m1_write(1'b0),
      .m1_waitrequest(fp_w1), .m1_readdatavalid(fp_v1), .m1_readdata(fp_d1),
      .s_address(fp_s_addr), .s_writedata(fp_s_wdata), .s_byteenable(fp_s_be),
      .s_burstcount(fp_s_bc), .s_read(fp_s_read), .s_write(fp_s_write),
      .s_waitrequest(1'b0), .s_readdatavalid(fp_rdv_in), .s_readdata(32'h12345678),
      .grant(fp_grant), .busy(fp_busy)
   );

   int n_chk = 0, n_fail = 0;
   logic [31:0] exp_wq [2][$];
   logic [31:0] exp_rq [2][$];
   logic [1:0]  glog [$];
   logic [1:0]  prev_grant;
   logic        acc_w [2], acc_r [2];
   int          rdv_cnt [2], wacc_cnt [2], acc_cyc [2], rdv_cyc [2];
   int          cyc = 0;
   int          wait_cfg = 0, rd_lat = 0, wcnt = 0;
   int          br_left = 0, br_cnt = 0, br_beat = 0;
   logic [AW-1:0] br_addr;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rdata(input logic [AW-1:0] a, input int b);
      logic [7:0] bb;
      bb = b[7:0];
      if (a == 22'h000100) return 32'hDEADBEEF;
      return {2'b01, a, bb};
   endfunction

   // Monitor: sample just before the rising edge what the DUT is about to commit
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         for (int m = 0; m < 2; m++) begin acc_w[m] = 1'b0; acc_r[m] = 1'b0; end
         prev_grant = 2'b00;
      end else begin
         for (int m = 0; m < 2; m++) begin
            acc_w[m] = s_write && !s_waitrequest && grant[m];
            acc_r[m] = s_read  && !s_waitrequest && grant[m];
            if (acc_r[m]) acc_cyc[m] = cyc;
            if (acc_w[m]) begin
               wacc_cnt[m]++;
               chk($sformatf("wq%0d_nonempty", m), exp_wq[m].size() != 0, 1);
               if (exp_wq[m].size() != 0) chk($sformatf("wdata_m%0d", m), s_writedata, exp_wq[m].pop_front());
            end
            if (m_rdv[m]) begin
               rdv_cnt[m]++;
               rdv_cyc[m] = cyc;
               chk($sformatf("rq%0d_nonempty", m), exp_rq[m].size() != 0, 1);
               if (exp_rq[m].size() != 0) chk($sformatf("rdata_m%0d", m), m_rdata[m], exp_rq[m].pop_front());
            end
            if ((m_read[m] || m_write[m]) && !grant[m]) chk($sformatf("stall_m%0d", m), m_wait[m], 1);
         end
         if (grant != prev_grant) begin glog.push_back(grant); prev_grant = grant; end
         if (acc_r[0] || acc_r[1]) begin
            br_left = (s_burstcount == 4'd0) ? 1 : int'(s_burstcount);
            br_addr = s_address; br_cnt = rd_lat; br_beat = 0;
         end
      end
   end

   // Bridge model: updates its outputs shortly after each rising edge
   always @(posedge clk) begin
      #2;
      if (!rst_n) begin
         s_waitrequest = 1'b1; s_readdatavalid = 1'b0; br_left = 0; wcnt = 0;
      end else begin
         if (s_read || s_write) begin
            if (wcnt < wait_cfg) begin s_waitrequest = 1'b1; wcnt++; end
            else begin s_waitrequest = 1'b0; wcnt = 0; end
         end else begin
            s_waitrequest = (wait_cfg != 0); wcnt = 0;
         end
         s_readdatavalid = 1'b0;
         if (br_left > 0) begin
            if (br_cnt == 0) begin
               s_readdatavalid = 1'b1; s_readdata = rdata(br_addr, br_beat);
               br_beat++; br_left--;
            end else br_cnt--;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin fp_acc = 1'b0; fp_prev = 2'b00; end
      else begin
         fp_acc = fp_s_read;
         if (fp_grant != fp_prev) begin
            if (fp_grant == 2'b01) fp_g0++;
            if (fp_grant == 2'b10) fp_g1++;
            fp_prev = fp_grant;
         end
      end
   end
   always @(posedge clk) begin #2; fp_rdv_in = rst_n && fp_acc; end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1;
      glog.delete();
   endtask

   task automatic check_log(input string tag, input int n, input logic [31:0] seq);
      logic [1:0] e;
      chk({tag, "_len"}, glog.size(), n);
      for (int i = 0; i < n && i < glog.size(); i++) begin
         e = seq[2*i +: 2];
         chk($sformatf("%s_%0d", tag, i), glog[i], e);
      end
      glog.delete();
   endtask

   task automatic mx(input int m, input bit rd, input logic [AW-1:0] a, input logic [31:0] d, input int bc);
      int eb, t, tgt;
      eb = (bc == 0) ? 1 : bc;
      m_address[m] = a; m_burstcount[m] = 4'(bc); m_byteenable[m] = 4'hF;
      if (rd) begin
         for (int b = 0; b < eb; b++) exp_rq[m].push_back(rdata(a, b));
         tgt = rdv_cnt[m] + eb;
         m_read[m] = 1'b1;
         t = 0;
         do begin @(posedge clk); #1; t++; end while (!acc_r[m] && t < TMO);
         chk($sformatf("tmo_racc_m%0d", m), t < TMO, 1);
         m_read[m] = 1'b0;
         t = 0;
         while (rdv_cnt[m] < tgt && t < TMO) begin @(posedge clk); #1; t++; end
         chk($sformatf("tmo_rdv_m%0d", m), t < TMO, 1);
      end else begin
         m_write[m] = 1'b1;
         for (int b = 0; b < eb; b++) begin
            m_writedata[m] = d + b;
            exp_wq[m].push_back(d + b);
            t = 0;
            do begin @(posedge clk); #1; t++; end while (!acc_w[m] && t < TMO);
            chk($sformatf("tmo_wacc_m%0d", m), t < TMO, 1);
         end
         m_write[m] = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int m = 0; m < 2; m++) begin
         m_address[m] = '0; m_writedata[m] = '0; m_byteenable[m] = '0; m_burstcount[m] = '0;
         m_read[m] = 1'b0; m_write[m] = 1'b0; rdv_cnt[m] = 0; wacc_cnt[m] = 0;
      end
      s_readdata = '0; s_waitrequest = 1'b1; s_readdatavalid = 1'b0; fp_rdv_in = 1'b0;
      rst_n = 1'b0;
      m_read[0] = 1'b1;
      idle(3);
      chk("rst_grant", grant, 2'b00);
      chk("rst_busy", busy, 0);
      chk("rst_wait0", m_wait[0], 1);
      chk("rst_wait1", m_wait[1], 1);
      chk("rst_sread", s_read, 0);
      chk("rst_swrite", s_write, 0);
      chk("rst_rdv", {m_rdv[1], m_rdv[0]}, 2'b00);
      m_read[0] = 1'b0;
      rst_n = 1'b1;
      idle(2);

      // Single m0 read, data 3 cycles after accept
      rd_lat = 2;
      mx(0, 1'b1, 22'h000100, 32'h0, 1);
      idle(2);
      chk("t1_lat", rdv_cyc[0] - acc_cyc[0], 3);
      chk("t1_rdv0", rdv_cnt[0], 1);
      chk("t1_rdv1", rdv_cnt[1], 0);
      check_log("t1_log", 2, 32'h1);

      // Simultaneous writes after reset, m0 first; m0 uses burstcount 0
      do_reset();
      fork
         mx(0, 1'b0, 22'h000010, 32'hA0A0_0000, 0);
         mx(1, 1'b0, 22'h000020, 32'hB1B1_0000, 1);
      join
      idle(2);
      check_log("t2_log", 4, 32'h21);

      // Continuous reads from both masters alternate strictly
      rd_lat = 0;
      fork
         for (int i = 0; i < 4; i++) mx(0, 1'b1, 22'h001000 + 22'(i), 32'h0, 1);
         for (int i = 0; i < 4; i++) mx(1, 1'b1, 22'h002000 + 22'(i), 32'h0, 2);
      join
      idle(2);
      check_log("t3_log", 16, 32'h21212121);

      // m1 burst of 3 with two wait cycles per beat, m0 write held off
      wait_cfg = 2;
      wacc_cnt[0] = 0; wacc_cnt[1] = 0;
      fork
         mx(1, 1'b0, 22'h003000, 32'hC0DE_0010, 3);
         begin idle(1); mx(0, 1'b0, 22'h004000, 32'h5555_0000, 1); end
      join
      idle(2);
      chk("t4_m1_beats", wacc_cnt[1], 3);
      chk("t4_m0_beats", wacc_cnt[0], 1);
      check_log("t4_log", 4, 32'h12);

      // m1 write requested while m0 read outstanding
      wait_cfg = 0; rd_lat = 3;
      fork
         mx(0, 1'b1, 22'h005000, 32'h0, 1);
         begin idle(1); mx(1, 1'b0, 22'h006000, 32'h7777_0001, 1); end
      join
      idle(2);
      check_log("t5_log", 4, 32'h21);

      // Stray readdatavalid in IDLE reaches nobody
      #2; s_readdatavalid = 1'b1; #1;
      chk("drop_rdv", {m_rdv[1], m_rdv[0]}, 2'b00);
      idle(2);

      // Reset during RD_WAIT
      rd_lat = 10;
      m_address[0] = 22'h007000; m_burstcount[0] = 4'd1; m_read[0] = 1'b1;
      for (int t = 0; t < TMO && !acc_r[0]; t++) idle(1);
      m_read[0] = 1'b0;
      idle(1);
      chk("t6_busy", busy, 1);
      rst_n = 1'b0;
      #2; s_readdatavalid = 1'b1; #1;
      chk("t6_grant", grant, 2'b00);
      chk("t6_wait0", m_wait[0], 1);
      chk("t6_wait1", m_wait[1], 1);
      chk("t6_rdv", {m_rdv[1], m_rdv[0]}, 2'b00);
      idle(1);
      rst_n = 1'b1;
      glog.delete();
      rd_lat = 1;
      mx(1, 1'b1, 22'h008000, 32'h0, 1);
      idle(2);
      check_log("t6_log", 2, 32'h2);

      chk("end_wq0", exp_wq[0].size(), 0);
      chk("end_wq1", exp_wq[1].size(), 0);
      chk("end_rq0", exp_rq[0].size(), 0);
      chk("end_rq1", exp_rq[1].size(), 0);
      chk("fp_m0_grants", fp_g0 >= 4, 1);
      chk("fp_m1_grants", fp_g1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/pci_avm_arbiter.md
Name: pci_avm_arbiter

Overview:
- Two-master round-robin arbiter that shares the PCI host bridge's single Avalon memory port (avm_*) between the CPU memory path (m0) and a DMA/blitter master (m1).
- Holds a grant for a complete transaction: every read beat returned, or every write beat accepted.
- Routes readdatavalid back to the owning master.
- Sits between the SoC interconnect and the bridge; the bridge supports one outstanding transaction only.

Parameters:
- AW, 22, address width (matches bridge avm_address).
- FIXED_PRIO, 0, 0 = round-robin; 1 = m0 always wins when both request.

Ports:
- clk  in  1  system clock (same as bridge clk)
- rst_n  in  1  asynchronous active-low reset
- mN_address  in  AW  master N address (N = 0, 1; all mN_* ports duplicated per master)
- mN_writedata  in  32  write data
- mN_byteenable  in  4  byte enables, active-high
- mN_burstcount  in  4  beats in transaction
- mN_read  in  1  read request
- mN_write  in  1  write request
- mN_waitrequest  out  1  stall to master N
- mN_readdatavalid  out  1  read beat valid for master N
- mN_readdata  out  32  read data (broadcast of s_readdata)
- s_address  out  AW  to bridge avm_address
- s_writedata  out  32  to bridge
- s_byteenable  out  4  to bridge
- s_burstcount  out  4  to bridge
- s_read  out  1  to bridge
- s_write  out  1  to bridge
- s_waitrequest  in  1  from bridge
- s_readdatavalid  in  1  from bridge
- s_readdata  in  32  from bridge
- grant  out  2  one-hot current owner {m1, m0}; 2'b00 = none
- busy  out  1  state != IDLE

Behaviour:
Reset state (async on rst_n low, any state): state=IDLE, grant=00, last_owner=m1 (so m0 wins first tie), beats=0. Outputs: mN_waitrequest=1, mN_readdatavalid=0, s_read=0, s_write=0. An outstanding transaction is abandoned; the bridge resets on the same rst_n.

States:
- IDLE
  - Both mN_waitrequest=1, s_read=s_write=0.
  - Requester = mN_read|mN_write.
  - One requester: grant it.
  - Two requesters: FIXED_PRIO=1 grants m0; otherwise grant the master != last_owner.
  - Grant registers at the clock edge → state OWN. Arbitration latency = 1 cycle.
- OWN
  - s_address, s_writedata, s_byteenable, s_burstcount, s_read, s_write = owner's signals, combinational mux.
  - owner waitrequest = s_waitrequest; non-owner waitrequest = 1.
  - Read accepted (s_read && !s_waitrequest): beats <= bc → RD_WAIT.
  - Write beat accepted (s_write && !s_waitrequest): if bc<=1, release; else beats <= bc-1 → WR_BURST.
  - bc = burstcount, with 0 treated as 1.
- WR_BURST
  - Same mux, s_read forced 0.
  - Each accepted beat decrements beats; release when beats reaches 0 on an accept.
- RD_WAIT
  - s_read=s_write=0; both waitrequest=1.
  - Each s_readdatavalid → owner readdatavalid=1 same cycle (combinational), beats-1.
  - Last beat: release.
  - s_readdatavalid while not in RD_WAIT is dropped: no master valid asserted.

Release: last_owner <= owner, grant <= 00, state <= IDLE. A new grant is possible the next cycle (no back-to-back without the IDLE cycle).

Rules and edge cases:
- Owner dropping read/write in OWN before acceptance (protocol violation): stays in OWN, no state change.
- mN_read and mN_write both high: read forwarded, s_write=0.
- Non-owner requests are held stalled and are never lost; mN_readdata = s_readdata always.

Test Plan:
- Single m0 read, addr 22'h000100, bridge returns 32'hDEADBEEF 3 cycles after accept → m0_readdatavalid one cycle with DEADBEEF; m1_readdatavalid stays 0; grant 01 then 00.
- m0 and m1 write requests asserted in the same cycle after reset, FIXED_PRIO=0 → m0 served first, then m1; grant sequence 01,00,10,00; s_writedata matches each owner.
- Both masters issue continuous reads, 4 transactions each → strict alternation m0,m1,m0,m1…; with FIXED_PRIO=1, all m0 first.
- m1 write burstcount=3, bridge waitrequest high 2 cycles per beat → exactly 3 accepted beats forwarded; m0 write pending meanwhile stays stalled; grant released only after beat 3.
- m0 read in progress, m1 write requested → m1_waitrequest=1 until m0 valid arrives, then m1 granted after one IDLE cycle.
- rst_n low during RD_WAIT → immediately grant=00, all waitrequest=1, readdatavalid=0; after release, new m1 read completes normally.
